hub75_bcm_scanner: RTL
======================

# hub75_bcm_scanner

Parametrised HUB75 scan engine that reads the framebuffer through the dual-port memory's second port and drives one or more chained RGB LED panels. It uses binary-code modulation (BCM) to produce BPC bits of intensity per colour channel. It scans HEIGHT/2 row pairs, shifting WIDTH*CHAINED columns per bit plane, and latches and displays each plane for a time weighted by 2^plane. It runs continuously while enabled and reports frame completion to the host logic.

## Interface
- WIDTH, 128, columns per panel
- HEIGHT, 64, rows per panel (even); ROW_BITS = clog2(HEIGHT/2)
- CHAINED, 1, panels in chain; N = WIDTH*CHAINED columns shifted per plane
- BPC, 4, bits per colour channel; BPP = 3*BPC, pixel = {R,G,B}, each MSB-first
- ON_BASE, 64, clk cycles of display for plane 0; plane p displays ON_BASE<<p
- ADDR_W, 14, memory address width; must be >= clog2(N*HEIGHT)
- clk  in  1  system clock
- RESET  in  1  reset, asynchronous, active-high
- enable  in  1  run request, sampled in IDLE and at each frame end
- mem_addr  out  ADDR_W  framebuffer read address, y*N + x
- mem_rd_en  out  1  read strobe; mem_data valid the cycle after
- mem_data  in  BPP  read data
- sclk, lat, oe  out  1 each  HUB75 shift clock, latch, output-enable (active-low)
- row_addr  out  ROW_BITS  HUB75 row select (A = bit 0)
- r0, g0, b0, r1, g1, b1  out  1 each  top-half / bottom-half colour data
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse after the last plane of the last row

## Operation
- States: IDLE → SHIFT → LATCH → DISPLAY → (SHIFT of next plane | SHIFT of next row | frame end).
- IDLE: oe=1, sclk=0, lat=0. If enable=1, go to SHIFT with row=0, plane=0 on the next cycle.
- SHIFT: N+1 slots of 4 cycles each (ph0..ph3); slot 0 is a prefetch lead-in.
  - Slot s < N, ph0: mem_addr = row*N + (N-1-s), mem_rd_en=1 (top pixel).
  - Slot s < N, ph1: mem_addr = (row+HEIGHT/2)*N + (N-1-s), mem_rd_en=1 (bottom pixel).
  - mem_rd_en=0 in all other SHIFT cycles.
  - At the end of ph3 of slot s < N: r0/g0/b0 = bit `plane` of top R/G/B; r1/g1/b1 = same bits of bottom pixel.
  - Slots 1..N: sclk=0 in ph0–ph1, sclk=1 in ph2–ph3. Slot 0: sclk=0 throughout.
  - Column N-1 is shifted first; exactly N sclk rising edges per plane.
- LATCH: 2 cycles, lat=1, oe=1. row_addr is updated to the current row on the first LATCH cycle. r/g/b are held.
- DISPLAY: oe=0 for exactly ON_BASE<<plane cycles; lat=0, sclk=0.
- DISPLAY exit:
  - plane < BPC-1: plane+1, go to SHIFT.
  - Otherwise plane=0 and row+1; if row was HEIGHT/2-1, row wraps to 0 and frame_done pulses on the cycle after the last DISPLAY cycle.
  - At frame end: enable=1 continues to SHIFT; enable=0 goes to IDLE.
- enable is ignored mid-frame; a frame is never truncated by deasserting enable.
- oe=1 in every state except DISPLAY. Panel is blank while shifting.
- Display counter width is clog2(ON_BASE<<(BPC-1)) + 1; no overflow or wrap is allowed.

## Timing
- Per plane p: 4*(N+1) + 2 + (ON_BASE<<p) cycles.
- Per row: BPC*(4N+6) + ON_BASE*(2^BPC - 1) cycles.
- Frame = (HEIGHT/2) * row time, plus 1 IDLE cycle when starting from IDLE.
- Defaults: 3032 cycles/row, 97024 cycles/frame.
- Memory read latency is exactly 1 cycle; there is no backpressure.
- All outputs are registered.
- Reset values: sclk=0, lat=0, oe=1, row_addr=0, r0..b1=0, mem_rd_en=0, mem_addr=0, busy=0, frame_done=0, state IDLE.
- RESET asserted mid-operation forces all outputs to their reset values immediately, without waiting for clk. After release, the block restarts from IDLE with row=0, plane=0.

## Test plan
Small configuration for all scenarios: WIDTH=4, HEIGHT=4, CHAINED=1, BPC=2, ON_BASE=4, with a 1-cycle-latency memory model.
- **Reset:** assert RESET mid-SHIFT → same cycle oe=1, sclk=0, lat=0, busy=0. Release with enable=1 → mem_rd_en first high 2 cycles later, with mem_addr=3.
- **Shift order/data:** pixel (x,y) = {R=x[1:0], G=y[1:0], B=2'b11}.
  - Plane 0, row 0: 4 sclk rises; r0 sequence 1,0,1,0 (x=3..0); b0=b1=1; g1=0.
  - Plane 1, row 0: r0 sequence 1,1,0,0.
- **BCM timing:** oe low runs of exactly 4 then 8 cycles per row. lat high exactly 2 cycles before each run. row_addr switches 0→1 during row 1's first LATCH.
- **Frame length:** enable held high → frame_done pulses every 112 cycles (first pulse 113 cycles after leaving IDLE). busy stays 1.
- **Enable drop:** deassert enable mid-row 0 → the frame completes, frame_done pulses, then IDLE (busy=0, oe=1). Re-assert → new frame starts from row 0.
- **Default configuration:** smoke test → frame_done period 97024 cycles. mem_addr never exceeds 8191.

Source files
------------

// File: rtl/hub75_bcm_scanner.sv
// hub75_bcm_scanner: BCM scan engine that reads a framebuffer port and drives chained HUB75 panels.
module hub75_bcm_scanner #(
  parameter  int WIDTH    = 128,
  parameter  int HEIGHT   = 64,
  parameter  int CHAINED  = 1,
  parameter  int BPC      = 4,
  parameter  int ON_BASE  = 64,
  parameter  int ADDR_W   = 14,
  localparam int ROW_BITS = $clog2(HEIGHT/2),
  localparam int BPP      = 3*BPC
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic                enable_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_rd_en_o,
  input  logic [BPP-1:0]      mem_data_i,
  output logic                sclk_o,
  output logic                lat_o,
  output logic                oe_o,
  output logic [ROW_BITS-1:0] row_addr_o,
  output logic                r0_o,
  output logic                g0_o,
  output logic                b0_o,
  output logic                r1_o,
  output logic                g1_o,
  output logic                b1_o,
  output logic                busy_o,
  output logic                frame_done_o
);
  localparam int N    = WIDTH*CHAINED;
  localparam int ROWS = HEIGHT/2;
  localparam int SW   = $clog2(N+1);
  localparam int PW   = BPC > 1 ? $clog2(BPC) : 1;
  localparam int CW   = $clog2(ON_BASE << (BPC-1)) + 1;
  localparam logic [SW-1:0]       SLOT_LAST  = SW'(N);
  localparam logic [ROW_BITS-1:0] ROW_LAST   = ROW_BITS'(ROWS-1);
  localparam logic [PW-1:0]       PLANE_LAST = PW'(BPC-1);
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;
  state_t              state_q, state_d;
  logic [ROW_BITS-1:0] row_q, row_d, row_addr_q, row_addr_d;
  logic [PW-1:0]       plane_q, plane_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [1:0]          ph_q, ph_d;
  logic [CW-1:0]       cnt_q, cnt_d, on_last;
  logic [BPP-1:0]      top_q, top_d, bot_q, bot_d;
  logic [5:0]          rgb_q, rgb_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_q, rd_d, sclk_q, sclk_d, lat_q, lat_d, oe_q, oe_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [BPC-1:0]      tr, tg, tb, br, bg, bb;
  assign {tr, tg, tb} = top_q;
  assign {br, bg, bb} = bot_q;
  assign on_last = (CW'(ON_BASE) << plane_q) - CW'(1);
  // Slot s reads top in ph0, bottom in ph1; data lands one cycle later and is presented at end of ph3.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    plane_d    = plane_q;
    slot_d     = slot_q;
    ph_d       = ph_q;
    cnt_d      = cnt_q;
    top_d      = top_q;
    bot_d      = bot_q;
    rgb_d      = rgb_q;
    row_addr_d = row_addr_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: if (enable_i) begin
        state_d = SHIFT;
        row_d   = '0;
        plane_d = '0;
        slot_d  = '0;
        ph_d    = '0;
      end
      SHIFT: begin
        ph_d = ph_q + 2'd1;
        if (ph_q == 2'd1) top_d = mem_data_i;
        if (ph_q == 2'd2) bot_d = mem_data_i;
        if (ph_q == 2'd3) begin
          if (slot_q != SLOT_LAST)
            rgb_d = {tr[plane_q], tg[plane_q], tb[plane_q], br[plane_q], bg[plane_q], bb[plane_q]};
          slot_d = slot_q + 1'b1;
          if (slot_q == SLOT_LAST) begin
            state_d    = LATCH;
            slot_d     = '0;
            row_addr_d = row_q;
          end
        end
      end
      LATCH: begin
        ph_d = ph_q + 2'd1;
        if (ph_q == 2'd1) begin
          state_d = DISPLAY;
          ph_d    = '0;
          cnt_d   = '0;
        end
      end
      DISPLAY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == on_last) begin
          state_d = SHIFT;
          slot_d  = '0;
          ph_d    = '0;
          if (plane_q != PLANE_LAST) plane_d = plane_q + 1'b1;
          else begin
            plane_d = '0;
            row_d   = row_q + 1'b1;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              done_d  = 1'b1;
              state_d = enable_i ? SHIFT : IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs are derived from the next state so they change together with it.
  always_comb begin
    rd_d   = state_d == SHIFT && slot_d != SLOT_LAST && !ph_d[1];
    addr_d = rd_d ? (ADDR_W'(row_d) + (ph_d[0] ? ADDR_W'(ROWS) : '0)) * ADDR_W'(N)
                    + ADDR_W'(N-1) - ADDR_W'(slot_d) : addr_q;
    sclk_d = state_d == SHIFT && slot_d != '0 && ph_d[1];
    lat_d  = state_d == LATCH;
    oe_d   = state_d != DISPLAY;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      row_q      <= '0;
      plane_q    <= '0;
      slot_q     <= '0;
      ph_q       <= '0;
      cnt_q      <= '0;
      top_q      <= '0;
      bot_q      <= '0;
      rgb_q      <= '0;
      row_addr_q <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      sclk_q     <= 1'b0;
      lat_q      <= 1'b0;
      oe_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      plane_q    <= plane_d;
      slot_q     <= slot_d;
      ph_q       <= ph_d;
      cnt_q      <= cnt_d;
      top_q      <= top_d;
      bot_q      <= bot_d;
      rgb_q      <= rgb_d;
      row_addr_q <= row_addr_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      sclk_q     <= sclk_d;
      lat_q      <= lat_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end
  assign mem_addr_o   = addr_q;
  assign mem_rd_en_o  = rd_q;
  assign sclk_o       = sclk_q;
  assign lat_o        = lat_q;
  assign oe_o         = oe_q;
  assign row_addr_o   = row_addr_q;
  assign {r0_o, g0_o, b0_o, r1_o, g1_o, b1_o} = rgb_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
endmodule
